reg574_seq: RTL and testbench
=============================

REG574_SEQ -- requirements
Module: reg574_seq

Interface
REQ-001 The block SHALL take parameter SETUP_CYC, default 1, giving the cycles d is stable before the strobe rises (legal 1..15).
REQ-002 The block SHALL take parameter PULSE_CYC, default 2, giving the cycles the ff_clk strobe stays high (legal 1..15).
REQ-003 The block SHALL take parameter HOLD_CYC, default 1, giving the cycles d is held after the strobe falls (legal 1..15).
REQ-004 The block SHALL take parameter RD_CYC, default 2, giving the cycles noe is held low before q_in is sampled (legal 1..15).
REQ-005 The ports SHALL be, one per line:
  clk     in   1  system clock; all state changes on the rising edge
  reset   in   1  asynchronous, active-high reset
  req     in   1  transaction request; held by the requester until ack
  we      in   1  1 = write, 0 = read; sampled with req
  addr    in   3  selects one of eight downstream 74x574 registers
  wdata   in   8  write data; sampled with req
  ack     out  1  one-cycle completion pulse
  busy    out  1  high while a transaction is in progress, including the ACK cycle
  d       out  8  shared D bus to all eight 574s
  ff_clk  out  8  per-register 574 clock strobe, one bit per addr
  noe     out  8  per-register 574 output enable, active low
  q_in    in   8  shared tri-state Q bus from the 574s
  rdata   out  8  last value captured by a read

Function
REQ-006 All outputs SHALL be driven directly from flops, with no combinational path from any input to ff_clk or noe, so that strobes are glitch-free.
REQ-007 The FSM SHALL have the states IDLE, SETUP, PULSE, HOLD, RDEN and ACK, and SHALL use a 4-bit phase counter.
REQ-008 In IDLE with req=1, the block SHALL latch addr, we and wdata; with we=1 it SHALL go to SETUP and load d=wdata; with we=0 it SHALL go to RDEN.
REQ-009 SETUP SHALL last SETUP_CYC cycles and then go to PULSE.
REQ-010 PULSE SHALL drive ff_clk[addr]=1 for exactly PULSE_CYC cycles, then go to HOLD; the other ff_clk bits SHALL stay 0.
REQ-011 HOLD SHALL drive ff_clk=0 for HOLD_CYC cycles, then go to ACK.
REQ-012 d SHALL stay constant from SETUP entry through HOLD exit.
REQ-013 d SHALL retain its last value in IDLE and during reads.
REQ-014 RDEN SHALL drive noe[addr]=0 for RD_CYC cycles.
REQ-015 On the final RDEN edge, the block SHALL capture rdata<=q_in (X/Z captured verbatim), set noe to 8'hFF, and go to ACK.
REQ-016 ACK SHALL assert ack=1 for one cycle, ignore req, and return to IDLE.
REQ-017 A request held across ACK SHALL be re-accepted in the following IDLE cycle.
REQ-018 Write latency SHALL be: req accepted at edge k, ack high during the cycle after edge k+SETUP_CYC+PULSE_CYC+HOLD_CYC+1 (defaults: ack during the 6th cycle).
REQ-019 Read latency SHALL be: ack high during the cycle after edge k+RD_CYC+1.
REQ-020 At most one noe bit SHALL be low at any time.
REQ-021 noe SHALL be 8'hFF whenever any ff_clk bit is 1.
REQ-022 At most one ff_clk bit SHALL be 1 at any time.
REQ-023 Changes on req, we, addr or wdata outside IDLE SHALL have no effect.

Reset
REQ-024 reset=1 SHALL immediately, without waiting for clk, force state=IDLE, counter=0, d=8'h00, ff_clk=8'h00, noe=8'hFF, ack=0, busy=0, rdata=8'h00.
REQ-025 Reset asserted during PULSE SHALL drop ff_clk asynchronously, and the aborted transaction SHALL never ack.
REQ-026 After reset deasserts, the first rising clk edge SHALL sample req normally.

Verification
REQ-027 The bench SHALL cover, with default parameters:
- Write addr=3, wdata=8'hA5 -> d=A5 one cycle before ff_clk=8'h08; strobe high 2 cycles; d held 1 cycle after the fall; ack pulses once, 6 cycles after acceptance.
- Read addr=5 with a 574 model driving 8'h3C -> noe=8'hDF for 2 cycles; rdata=3C; noe=FF in the ack cycle; d unchanged.
- req held continuously: write 0->8'h11, then read 0 -> second transaction starts the cycle after ack; readback 11; no overlap of ff_clk and noe.
- addr/wdata changed mid-write -> d and strobe select stay at the originally latched values.
- reset pulsed mid-PULSE -> ff_clk=0, noe=FF, d=00 within the same timestep; no ack; the next write completes normally.
- All eight addresses written with the values addr*8'h11, then read back -> every value matches; an assertion enforces REQ-020 through REQ-022 every cycle.

Source files
------------

// File: rtl/reg574_seq.sv
// ==========================================================================
// reg574_seq: sequencer for eight 74x574 registers on a shared D/Q bus
// Revision: 1.0
// ==========================================================================
`default_nettype none

module reg574_seq #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int RD_CYC    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic       ack,
  output logic       busy,
  output logic [7:0] d,
  output logic [7:0] ff_clk,
  output logic [7:0] noe,
  input  logic [7:0] q_in,
  output logic [7:0] rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    RDEN  = 3'd4,
    ACK   = 3'd5
  } state_t;

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RD_LAST    = 4'(RD_CYC - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] sel, sel_n;
  logic [7:0] d_n, ff_clk_n, noe_n, rdata_n;
  logic       ack_n, busy_n;

  // Every output is the Q of a flop below; this block only forms D inputs.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sel_n    = sel;
    d_n      = d;
    ff_clk_n = ff_clk;
    noe_n    = noe;
    rdata_n  = rdata;
    ack_n    = 1'b0;
    busy_n   = busy;
    case (state)
      IDLE: begin
        ff_clk_n = 8'h00;
        noe_n    = 8'hFF;
        busy_n   = req;
        if (req) begin
          sel_n = addr;
          if (we) begin
            state_n = SETUP;
            d_n     = wdata;
            cnt_n   = SETUP_LAST;
          end else begin
            state_n = RDEN;
            noe_n   = ~(8'd1 << addr);
            cnt_n   = RD_LAST;
          end
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_n  = PULSE;
          ff_clk_n = 8'd1 << sel;
          cnt_n    = PULSE_LAST;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      PULSE: begin
        if (cnt == 4'd0) begin
          state_n  = HOLD;
          ff_clk_n = 8'h00;
          cnt_n    = HOLD_LAST;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          state_n = ACK;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RDEN: begin
        if (cnt == 4'd0) begin
          state_n = ACK;
          rdata_n = q_in;
          noe_n   = 8'hFF;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ACK: begin
        // ack flop rises as we leave; the IDLE cycle that follows is the ack cycle.
        ack_n   = 1'b1;
        busy_n  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n  = IDLE;
        ff_clk_n = 8'h00;
        noe_n    = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      sel    <= 3'd0;
      d      <= 8'h00;
      ff_clk <= 8'h00;
      noe    <= 8'hFF;
      ack    <= 1'b0;
      busy   <= 1'b0;
      rdata  <= 8'h00;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sel    <= sel_n;
      d      <= d_n;
      ff_clk <= ff_clk_n;
      noe    <= noe_n;
      ack    <= ack_n;
      busy   <= busy_n;
      rdata  <= rdata_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg574_seq.sv
// ==========================================================================
// tb_reg574_seq: bench for reg574_seq with a behavioural 574 bank
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_reg574_seq;

  localparam int S = 1, P = 2, H = 1, R = 2;
  localparam int WR_LAT = S + P + H + 2;
  localparam int RD_LAT = R + 2;

  logic       clk, reset, req, we, ack, busy;
  logic [2:0] addr;
  logic [7:0] wdata, d, ff_clk, noe, q_in, rdata;

  reg574_seq #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .RD_CYC(R)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .busy(busy), .d(d), .ff_clk(ff_clk), .noe(noe), .q_in(q_in),
    .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Bank of eight 574s: capture d on a rising strobe, drive Q when enabled.
  logic [7:0] q_model [8] = '{default: 8'h00};
  logic [7:0] prev_ff = 8'h00;

  always_comb begin
    q_in = 8'h00;
    for (int i = 0; i < 8; i++)
      if (!noe[i]) q_in = q_model[i];
  end

  always @(negedge clk) begin
    if (!reset) begin
      ncmp++;
      assert ($onehot0(~noe) && $onehot0(ff_clk) && (!(|ff_clk) || noe == 8'hFF))
      else begin
        nfail++;
        $display("FAIL bus_exclusive: ff_clk=%h noe=%h (need one-hot0 each, noe=FF while strobing)",
                 ff_clk, noe);
      end
    end
    for (int i = 0; i < 8; i++)
      if (ff_clk[i] && !prev_ff[i]) q_model[i] = d;
    prev_ff = ff_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] tr_d [16], tr_ff [16], tr_noe [16];
  logic       tr_ack [16], tr_busy [16];

  // One request/ack handshake; per-cycle trace indexed from the cycle after acceptance.
  task automatic txn(input logic w, input logic [2:0] a, input logic [7:0] wd,
                     input bit scramble, output int lat);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = wd;
    lat = 0;
    for (int c = 1; c <= 15 && lat == 0; c++) begin
      @(negedge clk);
      tr_d[c] = d; tr_ff[c] = ff_clk; tr_noe[c] = noe;
      tr_ack[c] = ack; tr_busy[c] = busy;
      if (ack) begin
        lat = c;
        req = 1'b0;
      end else if (scramble) begin
        we = 1'($urandom); addr = 3'($urandom); wdata = 8'($urandom);
      end
    end
    req = 1'b0;
  endtask

  typedef struct {
    logic       w;
    logic [2:0] a;
    logic [7:0] wd;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t       tbl [16];
  logic [7:0] ref_mem [8];
  logic [7:0] last_wd;
  int         lat, cyc;
  bit         seen;

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[i].w = 1'b1;      tbl[i].a = 3'(i);     tbl[i].wd = 8'(i * 8'h11); tbl[i].exp_rd = 8'h00;
      tbl[8+i].w = 1'b0;    tbl[8+i].a = 3'(i);   tbl[8+i].wd = 8'h00;       tbl[8+i].exp_rd = 8'(i * 8'h11);
    end

    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 3'd0; wdata = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_d", d, 8'h00);
    chk("rst_ff_clk", ff_clk, 8'h00);
    chk("rst_noe", noe, 8'hFF);
    chk("rst_ack", ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    reset = 1'b0;

    // Basic write: setup, 2-cycle strobe, hold, ack in cycle 6
    txn(1'b1, 3'd3, 8'hA5, 1'b0, lat);
    chk("wr_lat", lat, WR_LAT);
    chk("wr_setup_d", tr_d[1], 8'hA5);
    chk("wr_setup_ff", tr_ff[1], 8'h00);
    chk("wr_pulse1_ff", tr_ff[2], 8'h08);
    chk("wr_pulse2_ff", tr_ff[3], 8'h08);
    chk("wr_hold_ff", tr_ff[4], 8'h00);
    chk("wr_hold_d", tr_d[4], 8'hA5);
    chk("wr_pre_ack", tr_ack[5], 1'b0);
    chk("wr_ack_busy", tr_busy[6], 1'b1);
    @(negedge clk);
    chk("wr_ack_once", ack, 1'b0);
    chk("wr_idle_busy", busy, 1'b0);

    // Read of a 574 holding 3C; d must keep the last written value
    txn(1'b1, 3'd5, 8'h3C, 1'b0, lat);
    txn(1'b1, 3'd1, 8'h77, 1'b0, lat);
    txn(1'b0, 3'd5, 8'hEE, 1'b0, lat);
    chk("rd_lat", lat, RD_LAT);
    chk("rd_noe1", tr_noe[1], 8'hDF);
    chk("rd_noe2", tr_noe[2], 8'hDF);
    chk("rd_noe3", tr_noe[3], 8'hFF);
    chk("rd_noe_ack", tr_noe[4], 8'hFF);
    chk("rd_data", rdata, 8'h3C);
    chk("rd_d_kept", d, 8'h77);

    // req held across ack: write 0<-11 then read 0 back to back
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 3'd0; wdata = 8'h11;
    seen = 1'b0; cyc = 0;
    for (int c = 1; c <= 15 && !seen; c++) begin
      @(negedge clk);
      if (ack) begin seen = 1'b1; cyc = c; end
    end
    chk("held_wr_lat", cyc, WR_LAT);
    we = 1'b0; wdata = 8'hEE;
    @(negedge clk);
    chk("held_rd_start", noe, 8'hFE);
    seen = 1'b0; cyc = 0;
    for (int c = 2; c <= 15 && !seen; c++) begin
      @(negedge clk);
      if (ack) begin seen = 1'b1; cyc = c; req = 1'b0; end
    end
    req = 1'b0;
    chk("held_rd_lat", cyc, RD_LAT);
    chk("held_rd_data", rdata, 8'h11);

    // Inputs scrambled after acceptance must not disturb the write
    txn(1'b1, 3'd6, 8'hC3, 1'b1, lat);
    chk("scr_lat", lat, WR_LAT);
    chk("scr_d2", tr_d[2], 8'hC3);
    chk("scr_d4", tr_d[4], 8'hC3);
    chk("scr_ff2", tr_ff[2], 8'h40);
    chk("scr_ff3", tr_ff[3], 8'h40);

    // Reset in the middle of the strobe
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 3'd2; wdata = 8'h5A;
    repeat (2) @(negedge clk);
    chk("abort_in_pulse", ff_clk, 8'h04);
    #2 reset = 1'b1; req = 1'b0;
    #1;
    chk("abort_ff_clk", ff_clk, 8'h00);
    chk("abort_noe", noe, 8'hFF);
    chk("abort_d", d, 8'h00);
    chk("abort_busy", busy, 1'b0);
    #1 reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    chk("abort_no_ack", seen, 1'b0);
    txn(1'b1, 3'd2, 8'h77, 1'b0, lat);
    chk("abort_next_lat", lat, WR_LAT);

    // Table: fill every address with addr*11, then read all back
    for (int i = 0; i < 16; i++) begin
      txn(tbl[i].w, tbl[i].a, tbl[i].wd, 1'b0, lat);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].w ? WR_LAT : RD_LAT);
      if (!tbl[i].w) chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rd);
      else           ref_mem[tbl[i].a] = tbl[i].wd;
    end
    last_wd = 8'h77;

    // Random traffic against a memory-level reference
    for (int n = 0; n < 40; n++) begin
      logic       w;
      logic [2:0] a;
      logic [7:0] wd;
      w = 1'($urandom); a = 3'($urandom_range(0, 7)); wd = 8'($urandom);
      txn(w, a, wd, 1'b1, lat);
      chk($sformatf("rnd%0d_lat", n), lat, w ? WR_LAT : RD_LAT);
      if (w) begin
        ref_mem[a] = wd;
        last_wd = wd;
      end else begin
        chk($sformatf("rnd%0d_rdata", n), rdata, ref_mem[a]);
      end
      chk($sformatf("rnd%0d_d", n), d, last_wd);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire
